// File: rtl/regfile_seq.sv
// regfile_seq: drives the 32x64 register file ports to bulk-load X0..X30 from a stream
// or dump X0..X31 to a stream, reading two registers per pass.
module regfile_seq #(
  parameter int N       = 64,
  parameter int LAST_WR = 30
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         mode,
  output logic         busy,
  output logic         done,
  output logic [4:0]   ra1,
  output logic [4:0]   ra2,
  input  logic [N-1:0] rd1,
  input  logic [N-1:0] rd2,
  output logic         we3,
  output logic [4:0]   wa3,
  output logic [N-1:0] wd3,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_data,
  output logic [4:0]   out_addr
);
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_DUMP_RD, S_DUMP_O0, S_DUMP_O1, S_DONE} state_t;
  state_t r_state, w_next;
  logic [4:0] r_idx, w_idx_nxt, w_idx1;
  logic [N-1:0] r_buf0, r_buf1;
  logic w_o0, w_o1, w_rd;
  assign w_idx1 = r_idx + 5'd1;
  assign w_o0 = r_state == S_DUMP_O0;
  assign w_o1 = r_state == S_DUMP_O1;
  assign w_rd = r_state == S_DUMP_RD;
  assign busy = r_state != S_IDLE;
  assign done = r_state == S_DONE;
  assign in_ready = r_state == S_LOAD;
  // load writes pass straight through so the write lands on the handshake edge
  assign we3 = in_ready && in_valid;
  assign wa3 = in_ready ? r_idx : '0;
  assign wd3 = in_ready ? in_data : '0;
  assign ra1 = w_rd ? r_idx : '0;
  assign ra2 = w_rd ? w_idx1 : '0;
  assign out_valid = w_o0 || w_o1;
  assign out_data = w_o0 ? r_buf0 : w_o1 ? r_buf1 : '0;
  assign out_addr = w_o0 ? r_idx : w_o1 ? w_idx1 : '0;
  always_comb begin
    w_next = r_state;
    w_idx_nxt = r_idx;
    case (r_state)
      S_IDLE: if (start) begin
        w_next = mode ? S_LOAD : S_DUMP_RD;
        w_idx_nxt = '0;
      end
      S_LOAD: if (in_valid) begin
        w_next = r_idx == 5'(LAST_WR) ? S_DONE : S_LOAD;
        w_idx_nxt = w_idx1;
      end
      S_DUMP_RD: w_next = S_DUMP_O0;
      S_DUMP_O0: if (out_ready) w_next = S_DUMP_O1;
      S_DUMP_O1: if (out_ready) begin
        w_next = r_idx == 5'd30 ? S_DONE : S_DUMP_RD;
        w_idx_nxt = r_idx + 5'd2;
      end
      default: w_next = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_idx <= '0;
      r_buf0 <= '0;
      r_buf1 <= '0;
    end else begin
      r_state <= w_next;
      r_idx <= w_idx_nxt;
      if (w_rd) begin
        r_buf0 <= rd1;
        r_buf1 <= rd2;
      end
    end
  end
endmodule

// File: tb/tb_regfile_seq.sv
// tb_regfile_seq: random-stimulus bench with a regfile model and a register-contents scoreboard.
module tb_regfile_seq;
  logic clk = 0, reset, start, mode;
  logic busy, done, we3, in_valid, in_ready, out_valid, out_ready;
  logic [4:0] ra1, ra2, wa3, out_addr;
  logic [63:0] rd1, rd2, wd3, in_data, out_data;
  logic [63:0] rf[32];
  logic [63:0] exp_rf[32];
  int n_checks = 0, n_fail = 0;

  always #5 clk = ~clk;

  regfile_seq dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .busy(busy), .done(done),
    .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2), .we3(we3), .wa3(wa3), .wd3(wd3),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_addr(out_addr)
  );

  assign rd1 = rf[ra1];
  assign rd2 = rf[ra2];

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = (i == 31) ? 64'd0 : 64'(i);
    forever begin
      @(posedge clk);
      if (we3 && wa3 != 5'd31) rf[wa3] <= wd3;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic run_dump(input int rmode, input int abort_at);
    int nb = 0, busy_n = 0, last_c = -1, done_c = -1;
    bit fin = 0, held = 0;
    logic [63:0] hd = '0;
    logic [4:0] ha = '0;
    @(posedge clk); #1;
    start = 1; mode = 0; out_ready = 0;
    for (int c = 0; c < 400 && !fin; c++) begin
      @(posedge clk); #1;
      start = (rmode == 3) ? 1'($urandom) : 1'b0;
      mode = 1'($urandom);
      out_ready = rmode == 1 ? (c % 4 == 0 || c % 4 == 3) : rmode == 2 ? 1'($urandom) : 1'b1;
      #1;
      if (busy) busy_n++;
      if (held) begin
        check("hold_valid", out_valid, 1);
        check("hold_data", out_data, hd);
        check("hold_addr", out_addr, ha);
      end
      held = out_valid && !out_ready;
      hd = out_data;
      ha = out_addr;
      if (out_valid && out_ready) begin
        check("dump_addr", out_addr, nb);
        check("dump_data", out_data, nb < 32 ? exp_rf[nb] : 64'hDEAD);
        nb++;
        last_c = c;
        if (nb == abort_at) fin = 1;
      end
      if (done) begin
        done_c = c;
        fin = 1;
      end
    end
    if (abort_at > 0) begin
      @(posedge clk); #1;
      reset = 1; out_ready = 0; start = 0;
      @(posedge clk); #1;
      reset = 0; #1;
      check("abort_beats", nb, abort_at);
      check("abort_valid", out_valid, 0);
      check("abort_busy", busy, 0);
      check("abort_done", done, 0);
    end else begin
      check("dump_beats", nb, 32);
      check("dump_done_at", done_c, last_c + 1);
      if (rmode == 0 || rmode == 3) check("dump_busy_cycles", busy_n, 49);
      @(posedge clk); #1;
      start = 0; out_ready = 0; #1;
      check("dump_idle_busy", busy, 0);
      check("dump_idle_done", done, 0);
    end
  endtask

  task automatic run_load(input int vmode, input int abort_at);
    int k = 0, busy_n = 0, last_c = -1, done_c = -1;
    bit fin = 0;
    @(posedge clk); #1;
    start = 1; mode = 1; in_valid = 0;
    for (int c = 0; c < 400 && !fin; c++) begin
      @(posedge clk); #1;
      start = 0;
      in_valid = vmode == 1 ? (c % 3 != 2) : vmode == 2 ? 1'($urandom) : 1'b1;
      in_data = vmode == 1 ? 64'hA000 + 64'(k) : {$urandom, $urandom};
      #1;
      if (busy) busy_n++;
      if (busy && !done) begin
        check("load_ready", in_ready, 1);
        check("load_we", we3, in_valid);
      end
      if (in_valid && in_ready) begin
        check("load_wa", wa3, k);
        check("load_wd", wd3, in_data);
        if (k < 31) exp_rf[k] = in_data;
        k++;
        last_c = c;
        if (k == abort_at) fin = 1;
      end
      if (done) begin
        done_c = c;
        fin = 1;
      end
    end
    if (abort_at > 0) begin
      @(posedge clk); #1;
      reset = 1; in_valid = 0; start = 0;
      @(posedge clk); #1;
      reset = 0; #1;
      check("load_abort_busy", busy, 0);
      check("load_abort_done", done, 0);
      check("load_abort_we", we3, 0);
    end else begin
      check("load_beats", k, 31);
      check("load_done_at", done_c, last_c + 1);
      if (vmode == 0) check("load_busy_cycles", busy_n, 32);
      @(posedge clk); #1;
      in_valid = 0; start = 0; #1;
      check("load_idle_busy", busy, 0);
      check("load_idle_we", we3, 0);
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) exp_rf[i] = (i == 31) ? 64'd0 : 64'(i);
    reset = 1; start = 0; mode = 0; in_valid = 0; in_data = '0; out_ready = 0;
    @(posedge clk); #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_we3", we3, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_addrs", {ra1, ra2, wa3, out_addr}, 0);
    check("rst_wd3", wd3, 0);
    check("rst_out_data", out_data, 0);
    @(posedge clk); #1;
    reset = 0;
    run_dump(0, 0);
    run_dump(1, 0);
    run_load(1, 0);
    run_dump(0, 0);
    run_dump(3, 0);
    run_dump(0, 10);
    run_dump(2, 0);
    run_load(0, 0);
    run_load(2, 5);
    run_dump(1, 0);
    run_load(2, 0);
    run_dump(2, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
